// File: rtl/fpcvt_pkg.sv
// Shared types and elaboration-time helpers for the sequential fixed-to-float converter.
// Each instance derives its exponent limit and shift-counter width from its own W/MW.
package fpcvt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fpcvt_state_e;

    // Largest exponent, which is also the maximum number of normalising shifts.
    function automatic int fpcvt_emax(input int w, input int mw);
        return w - mw - 1;
    endfunction

    function automatic int fpcvt_cntw(input int w, input int mw);
        return $clog2(w - mw);
    endfunction

    function automatic bit fpcvt_params_ok(input int w, input int ew, input int mw);
        return (mw >= 1) && (w >= mw + 2) && (((1 << ew) - 1) >= (w - mw - 1));
    endfunction

endpackage

// File: rtl/fpcvt_round.sv
// Combinational round-to-nearest with significand carry-out and exponent saturation.
// Shared with the pipelined converter variant.
module fpcvt_round #(
    parameter int EW   = 3,
    parameter int MW   = 4,
    parameter int EMAX = 7
) (
    input  logic [MW-1:0] i_fbase,
    input  logic          i_r,
    input  logic [EW-1:0] i_ebase,
    output logic [EW-1:0] o_e,
    output logic [MW-1:0] o_f
);

    localparam logic [EW-1:0] EMAX_E = EW'(EMAX);
    localparam logic [MW-1:0] F_ONES = '1;
    localparam logic [MW-1:0] F_HALF = MW'(1) << (MW - 1);

    // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_e = i_ebase;
        o_f = i_fbase;
        if (i_r) begin
            if (i_fbase != F_ONES) begin
                o_f = i_fbase + MW'(1);
            end else if (i_ebase < EMAX_E) begin
                // The significand carries out, so renormalise to 1.000 at the next exponent.
                o_f = F_HALF;
                o_e = i_ebase + EW'(1);
            end else begin
                o_f = F_ONES;
                o_e = EMAX_E;
            end
        end
    end

endmodule

// File: rtl/fpcvt_seq.sv
// Sequential W-bit two's-complement to (S, E, F) converter: one normalising shift per cycle,
// with valid/ready handshakes on both the input and the result.
module fpcvt_seq
    import fpcvt_pkg::*;
#(
    parameter int W      = 12,
    parameter int EW     = 3,
    parameter int MW     = 4,
    parameter bit RND_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  D,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          S,
    output logic [EW-1:0] E,
    output logic [MW-1:0] F
);

    localparam int EMAX = fpcvt_emax(W, MW);
    localparam int CNTW = fpcvt_cntw(W, MW);

    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(EMAX);
    localparam logic [W-1:0]    MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]    MAX_POS  = {1'b0, {(W-1){1'b1}}};

    if (!fpcvt_params_ok(W, EW, MW)) begin : g_bad_params
        $error("fpcvt_seq: need W >= MW+2 and 2**EW-1 >= W-MW-1");
    end

    fpcvt_state_e    r_state, w_next;
    logic [W-1:0]    r_mag;
    logic [CNTW-1:0] r_cnt;
    logic            r_sign;
    logic            r_s;
    logic [EW-1:0]   r_e;
    logic [MW-1:0]   r_f;

    logic [W-1:0]    w_mag_in;
    logic            w_norm_done;
    logic [MW-1:0]   w_fbase;
    logic            w_rbit;
    logic [EW-1:0]   w_ebase;
    logic [EW-1:0]   w_e;
    logic [MW-1:0]   w_f;

    // -2^(W-1) has no positive W-bit counterpart, so it is clamped to the largest magnitude.
    assign w_mag_in    = (D == MOST_NEG) ? MAX_POS : (D[W-1] ? -D : D);
    assign w_norm_done = r_mag[W-2] || (r_cnt == CNT_MAX);
    assign w_fbase     = r_mag[W-2 -: MW];
    assign w_rbit      = RND_EN ? r_mag[W-2-MW] : 1'b0;
    assign w_ebase     = EW'(EMAX) - EW'(r_cnt);

    fpcvt_round #(
        .EW   (EW),
        .MW   (MW),
        .EMAX (EMAX)
    ) u_round (
        .i_fbase (w_fbase),
        .i_r     (w_rbit),
        .i_ebase (w_ebase),
        .o_e     (w_e),
        .o_f     (w_f)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_next = NORM;
            NORM:    if (w_norm_done) w_next = ROUND;
            ROUND:                    w_next = DONE;
            DONE:    if (out_ready)   w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag  <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_s    <= 1'b0;
            r_e    <= '0;
            r_f    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= D[W-1];
                        r_mag  <= w_mag_in;
                        r_cnt  <= '0;
                    end
                end
                NORM: begin
                    if (!w_norm_done) begin
                        r_mag <= r_mag << 1;
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                ROUND: begin
                    // Result registers change only here, so they hold through DONE and IDLE.
                    r_s <= r_sign;
                    r_e <= w_e;
                    r_f <= w_f;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign S         = r_s;
    assign E         = r_e;
    assign F         = r_f;

endmodule

// File: tb/tb_fpcvt_seq.sv
// Self-checking bench for fpcvt_seq: arithmetic reference model, per-cycle result monitor,
// directed vectors, reset abort, random 12-bit traffic and a W=16/EW=4/MW=6 instance.
module tb_fpcvt_seq;

    localparam int W     = 12;
    localparam int EW    = 3;
    localparam int MW    = 4;
    localparam int EMAX  = 7;
    localparam int W2    = 16;
    localparam int EW2   = 4;
    localparam int MW2   = 6;
    localparam int EMAX2 = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  D = '0;
    logic          in_ready, out_valid, S;
    logic [EW-1:0] E;
    logic [MW-1:0] F;

    logic           v16 = 1'b0;
    logic           or16 = 1'b0;
    logic [W2-1:0]  d16 = '0;
    logic           rdy16, ov16, s16;
    logic [EW2-1:0] e16;
    logic [MW2-1:0] f16;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int s;
        int e;
        int f;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fpcvt_seq #(.W(W), .EW(EW), .MW(MW), .RND_EN(1'b1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .E         (E),
        .F         (F)
    );

    fpcvt_seq #(.W(W2), .EW(EW2), .MW(MW2), .RND_EN(1'b1)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v16),
        .in_ready  (rdy16),
        .D         (d16),
        .out_valid (ov16),
        .out_ready (or16),
        .S         (s16),
        .E         (e16),
        .F         (f16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: pick the exponent from the magnitude's bit length, round on the next bit down,
    // renormalise on carry-out and saturate past the top exponent. k is the shift count.
    function automatic void model(input int w, input int mw, input int emax,
                                  input longint unsigned d,
                                  output int s, output int e, output int f, output int k);
        longint m;
        longint fl;
        int     bl;
        s = int'((d >> (w - 1)) & 1);
        m = s ? (longint'(1) << w) - longint'(d) : longint'(d);
        if (m == (longint'(1) << (w - 1))) m = m - 1;
        bl = 0;
        while ((m >> bl) != 0) bl++;
        k  = (w - 1 - bl < emax) ? (w - 1 - bl) : emax;
        e  = (bl > mw) ? (bl - mw) : 0;
        fl = m >> e;
        if (e > 0) fl = fl + ((m >> (e - 1)) & 1);
        if (fl == (longint'(1) << mw)) begin
            fl = longint'(1) << (mw - 1);
            e  = e + 1;
        end
        if (e > emax) begin
            e  = emax;
            fl = (longint'(1) << mw) - 1;
        end
        f = int'(fl);
    endfunction

    // Whenever a result is presented it must match the oldest accepted input.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected out_valid", 64'd1, 64'd0);
            end else begin
                check("S", 64'(S), 64'(exp_q[0].s));
                check("E", 64'(E), 64'(exp_q[0].e));
                check("F", 64'(F), 64'(exp_q[0].f));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic convert(input logic [W-1:0] d, input int hold, input bit poke);
        int  s, e, f, k, n;
        bit  seen;
        model(W, MW, EMAX, 64'(d), s, e, f, k);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready before accept", 64'(in_ready), 64'd1);
        D        = d;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back('{s, e, f});
        #1;
        in_valid = 1'b0;
        check("in_ready after accept", 64'(in_ready), 64'd0);
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 20; i++) begin
            if (poke) begin
                D        = ~d;
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            if (poke) check("in_ready busy", 64'(in_ready), 64'd0);
            if (out_valid) begin
                seen = 1'b1;
                n    = i;
                break;
            end
        end
        check("latency", seen ? 64'(n) : 64'd0, 64'(k + 2));
        for (int i = 0; i < hold; i++) begin
            in_valid = poke;
            @(posedge clk); #1;
            check("in_ready held", 64'(in_ready), 64'd0);
            check("out_valid held", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid after handshake", 64'(out_valid), 64'd0);
        check("in_ready after handshake", 64'(in_ready), 64'd1);
    endtask

    task automatic pin(input logic [W-1:0] d, input int s, input int e, input int f, input int k,
                       input int hold, input bit poke);
        int ms, me, mf, mk;
        model(W, MW, EMAX, 64'(d), ms, me, mf, mk);
        check("model S", 64'(ms), 64'(s));
        check("model E", 64'(me), 64'(e));
        check("model F", 64'(mf), 64'(f));
        check("model k", 64'(mk), 64'(k));
        convert(d, hold, poke);
    endtask

    task automatic conv16(input logic [W2-1:0] d);
        int s, e, f, k, n;
        bit seen;
        model(W2, MW2, EMAX2, 64'(d), s, e, f, k);
        check("w16 in_ready", 64'(rdy16), 64'd1);
        d16 = d;
        v16 = 1'b1;
        @(posedge clk); #1;
        v16  = 1'b0;
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (ov16) begin
                seen = 1'b1;
                n    = i;
                break;
            end
        end
        check("w16 latency", seen ? 64'(n) : 64'd0, 64'(k + 2));
        check("w16 S", 64'(s16), 64'(s));
        check("w16 E", 64'(e16), 64'(e));
        check("w16 F", 64'(f16), 64'(f));
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check("w16 out_valid after handshake", 64'(ov16), 64'd0);
    endtask

    initial begin
        int ms, me, mf, mk;

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset S", 64'(S), 64'd0);
        check("reset E", 64'(E), 64'd0);
        check("reset F", 64'(F), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        pin(12'h02C, 0, 2, 4'b1011, 5, 0, 1'b0);
        pin(12'h07D, 0, 4, 4'b1000, 4, 0, 1'b0);
        pin(12'h7FF, 0, 7, 4'b1111, 0, 1, 1'b0);
        pin(12'h800, 1, 7, 4'b1111, 0, 0, 1'b0);
        pin(12'h000, 0, 0, 4'b0000, 7, 0, 1'b0);
        pin(12'h005, 0, 0, 4'b0101, 7, 2, 1'b0);
        pin(12'hFD4, 1, 2, 4'b1011, 5, 5, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("no result from ignored input", 64'(out_valid), 64'd0);

        // Abort a conversion mid-normalisation with an asynchronous reset.
        D        = 12'h005;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort F cleared", 64'(F), 64'd0);
        check("abort E cleared", 64'(E), 64'd0);
        check("abort S cleared", 64'(S), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("no result after abort", 64'(out_valid), 64'd0);
        convert(12'h02C, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            convert(12'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        model(W2, MW2, EMAX2, 64'h7FFF, ms, me, mf, mk);
        check("model16 E", 64'(me), 64'd9);
        check("model16 F", 64'(mf), 64'd63);
        conv16(16'h7FFF);
        conv16(16'h8000);
        conv16(16'h0001);
        conv16(16'h0000);
        conv16(16'hFFFF);
        for (int i = 0; i < 30; i++) begin
            conv16(16'($urandom));
        end

        check("expected queue drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
